// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB memory slave.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Byte lanes on a data bus of width dw
  function automatic int unsigned strb_width(int unsigned dw);
    return dw / 8;
  endfunction

  // Byte-offset bits within one data word
  function automatic int unsigned offs_bits(int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  // Wait counter width; at least one bit so a zero-wait build still elaborates
  function automatic int unsigned cnt_width(int unsigned wc);
    return (wc == 0) ? 1 : $clog2(wc + 1);
  endfunction

  // Widths for the default configuration (32-bit data, 2 wait states)
  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned STRB_WIDTH      = strb_width(DATA_WIDTH_DEF);
  localparam int unsigned OFFS_BITS       = offs_bits(DATA_WIDTH_DEF);
  localparam int unsigned CNT_WIDTH       = cnt_width(WAIT_CYCLES_DEF);

endpackage

// File: rtl/apb_byte_mem.sv
// DEPTH x DATA_WIDTH word storage with per-byte write enables,
// async clear and a combinational read port sharing the word index.
module apb_byte_mem
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic                              pclk,
  input  logic                              prst_n,
  input  logic                              we,
  input  logic [IDX_WIDTH-1:0]              idx,
  input  logic [strb_width(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int unsigned LANES = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage: cleared on reset, byte-lane masked update on write
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Combinational read of the addressed word
  assign rdata = mem[idx];

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 memory slave with byte strobes, configurable wait states and
// error response on out-of-range or misaligned accesses.
module apb_mem_slave_ws
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                              pclk,
  input  logic                              prst_n,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [strb_width(DATA_WIDTH)-1:0] pstrb,
  output logic                              pready,
  output logic                              pslverr,
  output logic [DATA_WIDTH-1:0]             prdata
);

  localparam int unsigned OFFS_W = offs_bits(DATA_WIDTH);
  localparam int unsigned CNT_W  = cnt_width(WAIT_CYCLES);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
  localparam int unsigned MEM_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   word_idx;
  logic [MEM_W-1:0]   mem_idx;
  logic               misaligned;
  logic               illegal;
  logic               mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Address decode: word index, alignment and range checks
  assign word_idx = paddr[ADDR_WIDTH-1:OFFS_W];

  generate
    if (OFFS_W > 0) begin : g_offs
      assign misaligned = |paddr[OFFS_W-1:0];
    end else begin : g_no_offs
      assign misaligned = 1'b0;
    end
  endgenerate

  assign illegal = misaligned || ({1'b0, word_idx} >= (IDX_W+1)'(DEPTH));
  assign mem_idx = illegal ? '0 : MEM_W'(word_idx);

  // State and wait counter registers
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait countdown and completion strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            pready  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion response and write enable; all zero outside a completing cycle
  assign mem_we  = pready && pwrite && !illegal;
  assign pslverr = pready && illegal;
  assign prdata  = (pready && !pwrite && !illegal) ? mem_rdata : '0;

  apb_byte_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (MEM_W)
  ) u_mem (
    .pclk   (pclk),
    .prst_n (prst_n),
    .we     (mem_we),
    .idx    (mem_idx),
    .be     (pstrb),
    .wdata  (pwdata),
    .rdata  (mem_rdata)
  );

endmodule
